// File: rtl/microondas_pkg.sv
// Shared types and constants for the microwave keypad front end.
package microondas_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StDebounce,
        StLoad,
        StClear,
        StWaitRelease
    } state_e;

    typedef logic [3:0] bcd_t;

    localparam logic [9:0] KEY_NONE = 10'd0;

endpackage

// File: rtl/keypad_loader_if.sv
// Digit-load / clear port between the keypad loader (master) and the timer (slave).
interface keypad_loader_if;
    import microondas_pkg::*;

    bcd_t data;
    logic loadn;
    logic timer_clrn;
    logic running;

    modport master (output data, output loadn, output timer_clrn, input running);
    modport slave  (input data, input loadn, input timer_clrn, output running);

endinterface

// File: rtl/onehot_bcd_encoder.sv
// Combinational 10-key one-hot to BCD encoder; valid only for exactly one active key.
module onehot_bcd_encoder
    import microondas_pkg::*;
(
    input  logic [9:0] keys,
    output logic       valid,
    output bcd_t       bcd
);

    always_comb begin
        bcd   = '0;
        valid = ($countones(keys) == 1);
        for (int i = 0; i < 10; i++) begin
            if (keys[i]) begin
                bcd = 4'(i);
            end
        end
        if (!valid) begin
            bcd = '0;
        end
    end

endmodule

// File: rtl/keypad_loader.sv
// Keypad digit-entry front end: synchronize, debounce, encode and strobe digits into the timer.
module keypad_loader
    import microondas_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned MAX_DIGITS      = 3,
    parameter int unsigned CNT_W           = 8
) (
    input  logic                   clk,
    input  logic                   clrn,
    input  logic [9:0]             keys,
    input  logic                   clear_key,
    keypad_loader_if.master        tmr,
    output logic [1:0]             digit_count,
    output logic                   full
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]       COUNT_MAX = 2'(MAX_DIGITS);

    logic [9:0]       kp_m, kp_q;
    logic             clr_m, clr_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    bcd_t             cap_q, cap_d;
    logic             cap_clr_q, cap_clr_d;
    bcd_t             data_q, data_d;
    logic             loadn_q, loadn_d;
    logic             tclrn_q, tclrn_d;
    logic [1:0]       count_q, count_d;
    logic             full_q, full_d;

    logic             key_valid;
    bcd_t             key_bcd;
    logic             changed;

    onehot_bcd_encoder u_encoder (
        .keys  (kp_q),
        .valid (key_valid),
        .bcd   (key_bcd)
    );

    // A clear press only tracks the clear button; a digit press must stay the same single key.
    assign changed = cap_clr_q ? !clr_q : (clr_q || !key_valid || (key_bcd != cap_q));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cap_d     = cap_q;
        cap_clr_d = cap_clr_q;
        data_d    = data_q;
        loadn_d   = 1'b1;
        tclrn_d   = 1'b1;
        count_d   = count_q;

        unique case (state_q)
            StIdle: begin
                if (!tmr.running) begin
                    if (clr_q) begin
                        state_d   = StDebounce;
                        cap_clr_d = 1'b1;
                        cnt_d     = '0;
                    end else if (key_valid) begin
                        state_d   = StDebounce;
                        cap_clr_d = 1'b0;
                        cap_d     = key_bcd;
                        cnt_d     = '0;
                    end
                end
            end
            StDebounce: begin
                if (tmr.running || changed) begin
                    state_d = StIdle;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = cap_clr_q ? StClear : StLoad;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StLoad: begin
                // Leading zeros and digits beyond the limit are silently dropped.
                if (!full_q && !((cap_q == 4'd0) && (count_q == 2'd0))) begin
                    data_d  = cap_q;
                    loadn_d = 1'b0;
                    count_d = count_q + 2'd1;
                end
                state_d = StWaitRelease;
                cnt_d   = '0;
            end
            StClear: begin
                tclrn_d = 1'b0;
                count_d = 2'd0;
                state_d = StWaitRelease;
                cnt_d   = '0;
            end
            StWaitRelease: begin
                if ((kp_q != KEY_NONE) || clr_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        full_d = (count_d == COUNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            kp_m      <= KEY_NONE;
            kp_q      <= KEY_NONE;
            clr_m     <= 1'b0;
            clr_q     <= 1'b0;
            state_q   <= StIdle;
            cnt_q     <= '0;
            cap_q     <= '0;
            cap_clr_q <= 1'b0;
            data_q    <= '0;
            loadn_q   <= 1'b1;
            tclrn_q   <= 1'b1;
            count_q   <= 2'd0;
            full_q    <= 1'b0;
        end else begin
            kp_m      <= keys;
            kp_q      <= kp_m;
            clr_m     <= clear_key;
            clr_q     <= clr_m;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cap_q     <= cap_d;
            cap_clr_q <= cap_clr_d;
            data_q    <= data_d;
            loadn_q   <= loadn_d;
            tclrn_q   <= tclrn_d;
            count_q   <= count_d;
            full_q    <= full_d;
        end
    end

    assign tmr.data       = data_q;
    assign tmr.loadn      = loadn_q;
    assign tmr.timer_clrn = tclrn_q;
    assign digit_count    = count_q;
    assign full           = full_q;

endmodule

// File: tb/tb_keypad_loader.sv
// Scoreboard bench for keypad_loader: expected strobes queued with stimulus, compared per scenario.
module tb_keypad_loader;
    import microondas_pkg::*;

    typedef struct packed {
        logic       clr;
        logic [3:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic [9:0] keys = '0;
    logic       clear_key = 1'b0;
    logic [1:0] digit_count;
    logic       full;

    keypad_loader_if tmr ();

    keypad_loader dut (
        .clk         (clk),
        .clrn        (clrn),
        .keys        (keys),
        .clear_key   (clear_key),
        .tmr         (tmr),
        .digit_count (digit_count),
        .full        (full)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    ev_t exp_q[$];
    ev_t got_ev[64];
    int  got_cyc[64];
    int  got_n = 0;
    int  rd = 0;
    int  cyc = 0;
    logic [11:0] tm_disp = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor plus a tiny timer display model (shift in digits, zero on clear).
    always @(negedge clk) begin
        if ((tmr.loadn === 1'b0 || tmr.timer_clrn === 1'b0) && got_n < 64) begin
            if (tmr.loadn === 1'b0 && tmr.timer_clrn === 1'b0) begin
                got_ev[got_n] <= '{clr: 1'b1, data: 4'hf};
            end else if (tmr.timer_clrn === 1'b0) begin
                got_ev[got_n] <= '{clr: 1'b1, data: 4'h0};
                tm_disp <= '0;
            end else begin
                got_ev[got_n] <= '{clr: 1'b0, data: tmr.data};
                tm_disp <= {tm_disp[7:0], tmr.data};
            end
            got_cyc[got_n] <= cyc;
            got_n <= got_n + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [9:0] kv, input logic cv, input int hold, input int rel,
                         output int t0);
        @(posedge clk);
        #1;
        t0 = cyc;
        keys = kv;
        clear_key = cv;
        tick(hold);
        keys = '0;
        clear_key = 1'b0;
        tick(rel);
    endtask

    task automatic test_reset();
        ev_t e;
        clrn = 1'b0;
        keys = 10'($urandom);
        clear_key = 1'($urandom);
        tick(2);
        @(negedge clk);
        n_cmp += 5;
        if (tmr.loadn !== 1'b1) begin
            n_fail++; $display("FAIL reset_loadn: got %b want 1", tmr.loadn);
        end
        if (tmr.timer_clrn !== 1'b1) begin
            n_fail++; $display("FAIL reset_timer_clrn: got %b want 1", tmr.timer_clrn);
        end
        if (tmr.data !== 4'd0) begin
            n_fail++; $display("FAIL reset_data: got %0d want 0", tmr.data);
        end
        if (digit_count !== 2'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d want 0", digit_count);
        end
        if (full !== 1'b0) begin
            n_fail++; $display("FAIL reset_full: got %b want 0", full);
        end
        @(posedge clk);
        #1;
        clrn = 1'b1;
        keys = '0;
        clear_key = 1'b0;
        tick(12);
        while (exp_q.size() > 0) e = exp_q.pop_front();
        n_cmp++;
        if (got_n !== rd) begin
            n_fail++; $display("FAIL reset_strobes: got %0d strobes want 0", got_n - rd);
            rd = got_n;
        end
    endtask

    task automatic test_entry();
        ev_t e;
        int  t0, tdummy, first;
        first = rd;
        exp_q.push_back('{clr: 1'b0, data: 4'd1});
        press(10'd1 << 1, 1'b0, 10, 10, t0);
        exp_q.push_back('{clr: 1'b0, data: 4'd2});
        press(10'd1 << 2, 1'b0, 10, 10, tdummy);
        exp_q.push_back('{clr: 1'b0, data: 4'd9});
        press(10'd1 << 9, 1'b0, 10, 10, tdummy);
        n_cmp++;
        if (got_n <= first || got_cyc[first] !== t0 + 8) begin
            n_fail++;
            $display("FAIL entry_latency: got cycle %0d want %0d", got_cyc[first] - t0, 8);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (rd >= got_n) begin
                n_fail++; $display("FAIL entry_strobe: missing, want clr=%0b data=%0d", e.clr, e.data);
            end else begin
                if (got_ev[rd] !== e) begin
                    n_fail++;
                    $display("FAIL entry_strobe: got clr=%0b data=%0d want clr=%0b data=%0d",
                             got_ev[rd].clr, got_ev[rd].data, e.clr, e.data);
                end
                rd++;
            end
        end
        @(negedge clk);
        n_cmp += 4;
        if (got_n !== rd) begin
            n_fail++; $display("FAIL entry_extra: got %0d extra strobes want 0", got_n - rd);
            rd = got_n;
        end
        if (digit_count !== 2'd3) begin
            n_fail++; $display("FAIL entry_count: got %0d want 3", digit_count);
        end
        if (full !== 1'b1) begin
            n_fail++; $display("FAIL entry_full: got %b want 1", full);
        end
        if (tm_disp !== 12'h129) begin
            n_fail++; $display("FAIL entry_display: got %h want 129", tm_disp);
        end
    endtask

    task automatic test_bounce();
        ev_t e;
        int  t0;
        exp_q.push_back('{clr: 1'b1, data: 4'd0});
        press('0, 1'b1, 10, 10, t0);
        for (int i = 0; i < 6; i++) begin
            keys = (i % 2 == 0) ? (10'd1 << 5) : '0;
            tick(2);
        end
        exp_q.push_back('{clr: 1'b0, data: 4'd5});
        keys = 10'd1 << 5;
        tick(10);
        keys = '0;
        tick(10);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (rd >= got_n) begin
                n_fail++; $display("FAIL bounce_strobe: missing, want clr=%0b data=%0d", e.clr, e.data);
            end else begin
                if (got_ev[rd] !== e) begin
                    n_fail++;
                    $display("FAIL bounce_strobe: got clr=%0b data=%0d want clr=%0b data=%0d",
                             got_ev[rd].clr, got_ev[rd].data, e.clr, e.data);
                end
                rd++;
            end
        end
        @(negedge clk);
        n_cmp += 2;
        if (got_n !== rd) begin
            n_fail++; $display("FAIL bounce_extra: got %0d extra strobes want 0", got_n - rd);
            rd = got_n;
        end
        if (digit_count !== 2'd1) begin
            n_fail++; $display("FAIL bounce_count: got %0d want 1", digit_count);
        end
    endtask

    task automatic test_zero_overflow();
        ev_t e;
        int  t0;
        int  seq[5] = '{0, 4, 0, 0, 7};
        exp_q.push_back('{clr: 1'b1, data: 4'd0});
        press('0, 1'b1, 10, 10, t0);
        exp_q.push_back('{clr: 1'b0, data: 4'd4});
        exp_q.push_back('{clr: 1'b0, data: 4'd0});
        exp_q.push_back('{clr: 1'b0, data: 4'd0});
        foreach (seq[i]) press(10'd1 << seq[i], 1'b0, 10, 10, t0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (rd >= got_n) begin
                n_fail++; $display("FAIL zero_strobe: missing, want clr=%0b data=%0d", e.clr, e.data);
            end else begin
                if (got_ev[rd] !== e) begin
                    n_fail++;
                    $display("FAIL zero_strobe: got clr=%0b data=%0d want clr=%0b data=%0d",
                             got_ev[rd].clr, got_ev[rd].data, e.clr, e.data);
                end
                rd++;
            end
        end
        @(negedge clk);
        n_cmp += 3;
        if (got_n !== rd) begin
            n_fail++; $display("FAIL zero_extra: got %0d extra strobes want 0", got_n - rd);
            rd = got_n;
        end
        if (digit_count !== 2'd3) begin
            n_fail++; $display("FAIL zero_count: got %0d want 3", digit_count);
        end
        if (full !== 1'b1) begin
            n_fail++; $display("FAIL zero_full: got %b want 1", full);
        end
    endtask

    task automatic test_lockout_clear();
        ev_t e;
        int  t0;
        exp_q.push_back('{clr: 1'b1, data: 4'd0});
        press('0, 1'b1, 10, 10, t0);
        exp_q.push_back('{clr: 1'b0, data: 4'd2});
        press(10'd1 << 2, 1'b0, 10, 10, t0);
        tmr.running = 1'b1;
        press(10'd1 << 3, 1'b0, 10, 10, t0);
        @(negedge clk);
        n_cmp++;
        if (digit_count !== 2'd1) begin
            n_fail++; $display("FAIL lock_count: got %0d want 1", digit_count);
        end
        tmr.running = 1'b0;
        exp_q.push_back('{clr: 1'b1, data: 4'd0});
        press(10'd1 << 8, 1'b1, 10, 10, t0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (rd >= got_n) begin
                n_fail++; $display("FAIL lock_strobe: missing, want clr=%0b data=%0d", e.clr, e.data);
            end else begin
                if (got_ev[rd] !== e) begin
                    n_fail++;
                    $display("FAIL lock_strobe: got clr=%0b data=%0d want clr=%0b data=%0d",
                             got_ev[rd].clr, got_ev[rd].data, e.clr, e.data);
                end
                rd++;
            end
        end
        @(negedge clk);
        n_cmp += 2;
        if (got_n !== rd) begin
            n_fail++; $display("FAIL lock_extra: got %0d extra strobes want 0", got_n - rd);
            rd = got_n;
        end
        if (digit_count !== 2'd0) begin
            n_fail++; $display("FAIL clear_count: got %0d want 0", digit_count);
        end
    endtask

    task automatic test_reset_midop();
        ev_t e;
        @(posedge clk);
        #1;
        keys = 10'd1 << 6;
        tick(4);
        clrn = 1'b0;
        tick(2);
        @(negedge clk);
        n_cmp++;
        if (tmr.loadn !== 1'b1) begin
            n_fail++; $display("FAIL midreset_loadn: got %b want 1", tmr.loadn);
        end
        @(posedge clk);
        #1;
        clrn = 1'b1;
        exp_q.push_back('{clr: 1'b0, data: 4'd6});
        tick(14);
        keys = '0;
        tick(10);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (rd >= got_n) begin
                n_fail++; $display("FAIL midreset_strobe: missing, want clr=%0b data=%0d", e.clr, e.data);
            end else begin
                if (got_ev[rd] !== e) begin
                    n_fail++;
                    $display("FAIL midreset_strobe: got clr=%0b data=%0d want clr=%0b data=%0d",
                             got_ev[rd].clr, got_ev[rd].data, e.clr, e.data);
                end
                rd++;
            end
        end
        @(negedge clk);
        n_cmp += 2;
        if (got_n !== rd) begin
            n_fail++; $display("FAIL midreset_extra: got %0d extra strobes want 0", got_n - rd);
            rd = got_n;
        end
        if (digit_count !== 2'd1) begin
            n_fail++; $display("FAIL midreset_count: got %0d want 1", digit_count);
        end
    endtask

    initial begin
        tmr.running = 1'b0;
        test_reset();
        test_entry();
        test_bounce();
        test_zero_overflow();
        test_lockout_clear();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
